vga_timing_ctrl: RTL and testbench

Sequences the tic-tac-toe display pipeline: generates a 1-in-DIV pixel strobe from the system clock and advances horizontal and vertical raster counters on that strobe. Also produces VGA sync, blanking, line and frame markers, and the 3x3 board cell coordinate of the current pixel. It sits between the system clock and the pixel renderer and VGA pins. It replaces free-running divided clocks with a single-clock-domain enable scheme.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/pixel_strobe_gen.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 153 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing and tic-tac-toe board geometry.
//   COORD_W        : width of pixel_x / pixel_y
//   VGA_*          : default timing (640x480 @ 60 Hz, 25 MHz pixel rate from 100 MHz)
//   cell_t         : registered board-cell decode (valid, column, row)
//   in_range()     : half-open range test on a coordinate, lo <= v < hi
package vga_pkg;

  localparam int COORD_W      = 10;

  localparam int VGA_DIV      = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_GRID_X0  = 170;
  localparam int VGA_GRID_Y0  = 90;
  localparam int VGA_CELL     = 100;

  typedef struct packed {
    logic       valid;
    logic [1:0] col;
    logic [1:0] row;
  } cell_t;

  function automatic logic in_range(input logic [COORD_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Pixel-rate enable generator: counts 0..DIV-1 on enabled cycles.
//   clock_in   : system clock
//   reset      : asynchronous, active-high
//   enable     : high = count advances, low = count holds
//   tick_next  : combinational, high when the next edge starts a pixel
//   pixel_tick : registered strobe, high for the one cycle the count sits at DIV-1
module pixel_strobe_gen #(
  parameter int DIV = 4
) (
  input  logic clock_in,
  input  logic reset,
  input  logic enable,
  output logic tick_next,
  output logic pixel_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt;

  // The count only enters DIV-1 through an enabled step, so a count frozen
  // at DIV-1 never re-fires the strobe.
  assign tick_next = enable && (cnt == PRE);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      pixel_tick <= tick_next;
      if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing for the tic-tac-toe display, single clock domain.
//   clock_in, reset          : system clock, asynchronous active-high reset
//   enable                   : high = raster runs, low = everything freezes
//   pixel_tick               : one-cycle pixel strobe (1 in DIV enabled cycles)
//   pixel_x, pixel_y         : current raster position
//   hsync, vsync             : active-low sync
//   video_on                 : inside the active area
//   line_start, frame_start  : pulse with the tick that enters x=0 / (0,0)
//   cell_valid, cell_col/row : 3x3 board cell of the current pixel
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int DIV      = VGA_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int GRID_X0  = VGA_GRID_X0,
  parameter int GRID_Y0  = VGA_GRID_Y0,
  parameter int CELL     = VGA_CELL
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               enable,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               cell_valid,
  output logic [1:0]         cell_col,
  output logic [1:0]         cell_row
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CELL_W  = (CELL > 1) ? $clog2(CELL) : 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CELL_W-1:0]  sub_t;

  localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t GX0      = coord_t'(GRID_X0);
  localparam coord_t GY0      = coord_t'(GRID_Y0);
  localparam sub_t   SUB_LAST = sub_t'(CELL - 1);

  logic   tick_next;
  coord_t x_n, y_n;
  sub_t   cx_q, cx_n, ry_q, ry_n;
  logic [1:0] col_q, col_n, row_q, row_n;
  logic   hs_n, vs_n, von_n;
  cell_t  cell_n, cell_q;

  pixel_strobe_gen #(.DIV(DIV)) u_strobe (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .tick_next  (tick_next),
    .pixel_tick (pixel_tick)
  );

  // Everything is decoded from the position the next tick moves to, so the
  // registered decode lines up with the registered position.
  always_comb begin
    x_n = pixel_x + 1'b1;
    y_n = pixel_y;
    if (pixel_x == X_LAST) begin
      x_n = '0;
      y_n = (pixel_y == Y_LAST) ? '0 : pixel_y + 1'b1;
    end

    // Column sub-counter: restarts at the board's left edge every line and
    // steps each CELL pixels; its value outside the board is don't-care.
    cx_n  = cx_q + 1'b1;
    col_n = col_q;
    if (x_n == GX0) begin
      cx_n  = '0;
      col_n = '0;
    end else if (cx_q == SUB_LAST) begin
      cx_n  = '0;
      col_n = col_q + 1'b1;
    end

    // Row sub-counter: same scheme, stepped once per line.
    ry_n  = ry_q;
    row_n = row_q;
    if (x_n == '0) begin
      if (y_n == GY0) begin
        ry_n  = '0;
        row_n = '0;
      end else if (ry_q == SUB_LAST) begin
        ry_n  = '0;
        row_n = row_q + 1'b1;
      end else begin
        ry_n  = ry_q + 1'b1;
      end
    end

    hs_n  = !in_range(x_n, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    vs_n  = !in_range(y_n, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    von_n = in_range(x_n, 0, H_ACTIVE) && in_range(y_n, 0, V_ACTIVE);

    cell_n.valid = von_n && in_range(x_n, GRID_X0, GRID_X0 + 3 * CELL)
                         && in_range(y_n, GRID_Y0, GRID_Y0 + 3 * CELL);
    cell_n.col   = cell_n.valid ? col_n : 2'd0;
    cell_n.row   = cell_n.valid ? row_n : 2'd0;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      pixel_x     <= X_LAST;
      pixel_y     <= Y_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      cell_q      <= '0;
      cx_q        <= '0;
      ry_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= tick_next && (x_n == '0);
      frame_start <= tick_next && (x_n == '0) && (y_n == '0);
      if (tick_next) begin
        pixel_x  <= x_n;
        pixel_y  <= y_n;
        hsync    <= hs_n;
        vsync    <= vs_n;
        video_on <= von_n;
        cell_q   <= cell_n;
        cx_q     <= cx_n;
        ry_q     <= ry_n;
        col_q    <= col_n;
        row_q    <= row_n;
      end
    end
  end

  assign cell_valid = cell_q.valid;
  assign cell_col   = cell_q.col;
  assign cell_row   = cell_q.row;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a scaled-down raster (28x19) so
// whole frames fit in a few thousand cycles. The stimulus side pushes one
// expected record per pixel tick; the monitor pops on every DUT tick and
// checks held outputs on all other cycles.
module tb_vga_timing_ctrl;

  localparam int DIV = 4;
  localparam int HA = 20, HF = 2, HS = 3, HB = 3;
  localparam int VA = 14, VF = 1, VS = 2, VB = 2;
  localparam int GX = 4, GY = 1, C = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b0;
  logic       pixel_tick, hsync, vsync, video_on, line_start, frame_start, cell_valid;
  logic [9:0] pixel_x, pixel_y;
  logic [1:0] cell_col, cell_row;

  always #5 clock_in = ~clock_in;

  vga_timing_ctrl #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_X0(GX), .GRID_Y0(GY), .CELL(C)
  ) dut (
    .clock_in(clock_in), .reset(reset), .enable(enable),
    .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start),
    .cell_valid(cell_valid), .cell_col(cell_col), .cell_row(cell_row)
  );

  typedef struct {
    int cyc; int x; int y;
    bit hs; bit vs; bit von; bit cv; int col; int row;
    bit tk; bit ls; bit fs;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  always @(posedge clock_in) cyc <= cyc + 1;

  // Hand-computed points: x, y, hsync, vsync, video_on, cell_valid, col, row
  int dv [0:17][0:7] = '{
    '{ 3,  2, 1, 1, 1, 0, 0, 0}, '{ 4,  2, 1, 1, 1, 1, 0, 0},
    '{ 8,  2, 1, 1, 1, 1, 1, 0}, '{12,  2, 1, 1, 1, 1, 2, 0},
    '{15,  2, 1, 1, 1, 1, 2, 0}, '{16,  2, 1, 1, 1, 0, 0, 0},
    '{ 8,  6, 1, 1, 1, 1, 1, 1}, '{ 4,  9, 1, 1, 1, 1, 0, 2},
    '{15, 12, 1, 1, 1, 1, 2, 2}, '{ 4, 13, 1, 1, 1, 0, 0, 0},
    '{ 4,  0, 1, 1, 1, 0, 0, 0}, '{19,  5, 1, 1, 1, 0, 0, 0},
    '{20,  5, 1, 1, 0, 0, 0, 0}, '{22,  5, 0, 1, 0, 0, 0, 0},
    '{25,  5, 1, 1, 0, 0, 0, 0}, '{ 0, 15, 1, 0, 0, 0, 0, 0},
    '{ 0, 16, 1, 0, 0, 0, 0, 0}, '{ 0, 17, 1, 1, 0, 0, 0, 0}
  };
  bit dir_hit [0:17];

  function automatic exp_t model(input int x, input int y);
    exp_t m;
    m.cyc = 0; m.x = x; m.y = y;
    m.hs  = !(x >= HA + HF && x < HA + HF + HS);
    m.vs  = !(y >= VA + VF && y < VA + VF + VS);
    m.von = (x < HA) && (y < VA);
    m.cv  = m.von && x >= GX && x < GX + 3 * C && y >= GY && y < GY + 3 * C;
    m.col = m.cv ? (x - GX) / C : 0;
    m.row = m.cv ? (y - GY) / C : 0;
    m.tk  = 1'b1;
    m.ls  = (x == 0);
    m.fs  = (x == 0) && (y == 0);
    return m;
  endfunction

  function automatic exp_t rst_rec();
    exp_t m;
    m = model(HT - 1, VT - 1);
    m.hs = 1'b1; m.vs = 1'b1; m.von = 1'b0; m.cv = 1'b0; m.col = 0; m.row = 0;
    m.tk = 1'b0; m.ls = 1'b0; m.fs = 1'b0;
    return m;
  endfunction

  task automatic check(input string tag, input exp_t e);
    bit bad;
    n_tests++;
    bad = (int'(pixel_x) != e.x) || (int'(pixel_y) != e.y) ||
          (hsync !== e.hs) || (vsync !== e.vs) || (video_on !== e.von) ||
          (cell_valid !== e.cv) || (int'(cell_col) != e.col) || (int'(cell_row) != e.row) ||
          (pixel_tick !== e.tk) || (line_start !== e.ls) || (frame_start !== e.fs);
    if (bad) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b von=%b cv=%b col=%0d row=%0d tk=%b ls=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b von=%b cv=%b col=%0d row=%0d tk=%b ls=%b fs=%b",
               tag, cyc, pixel_x, pixel_y, hsync, vsync, video_on, cell_valid, cell_col, cell_row,
               pixel_tick, line_start, frame_start, e.x, e.y, e.hs, e.vs, e.von, e.cv, e.col, e.row,
               e.tk, e.ls, e.fs);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t hold, me;
  int   hs_cnt, vs_cnt, since_fs;
  bit   line_seen, frame_seen;

  always @(negedge clock_in) begin
    if (reset) begin
      hold = rst_rec();
      check("reset_values", hold);
      line_seen  = 1'b0;
      frame_seen = 1'b0;
    end else if (pixel_tick) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_tick cyc=%0d got tick at x=%0d y=%0d expected no tick", cyc, pixel_x, pixel_y);
      end else begin
        me = q.pop_front();
        chk_int("tick_cycle", cyc, me.cyc);
        check("tick", me);
        hold = me; hold.tk = 1'b0; hold.ls = 1'b0; hold.fs = 1'b0;
      end
      for (int k = 0; k < 18; k++) begin
        if (int'(pixel_x) == dv[k][0] && int'(pixel_y) == dv[k][1]) begin
          dir_hit[k] = 1'b1;
          n_tests++;
          if (hsync !== 1'(dv[k][2]) || vsync !== 1'(dv[k][3]) || video_on !== 1'(dv[k][4]) ||
              cell_valid !== 1'(dv[k][5]) || int'(cell_col) != dv[k][6] || int'(cell_row) != dv[k][7]) begin
            n_fail++;
            $display("FAIL directed(%0d,%0d) got hs=%b vs=%b von=%b cv=%b col=%0d row=%0d expected hs=%0d vs=%0d von=%0d cv=%0d col=%0d row=%0d",
                     dv[k][0], dv[k][1], hsync, vsync, video_on, cell_valid, cell_col, cell_row,
                     dv[k][2], dv[k][3], dv[k][4], dv[k][5], dv[k][6], dv[k][7]);
          end
        end
      end
      if (frame_start) begin
        if (frame_seen) begin
          chk_int("frame_ticks", since_fs, HT * VT);
          chk_int("vsync_lines", vs_cnt, VS);
        end
        frame_seen = 1'b1; since_fs = 0; vs_cnt = 0;
      end
      if (line_start) begin
        if (line_seen) chk_int("hsync_ticks", hs_cnt, HS);
        line_seen = 1'b1; hs_cnt = 0;
        if (!vsync) vs_cnt++;
      end
      since_fs++;
      if (!hsync) hs_cnt++;
    end else begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missing_tick cyc=%0d got no tick expected tick to x=%0d y=%0d", cyc, me.x, me.y);
        hold = me; hold.tk = 1'b0; hold.ls = 1'b0; hold.fs = 1'b0;
      end else begin
        check("hold", hold);
      end
    end
  end

  // ---------------- stimulus + expectation ----------------
  int mx, my, p;
  bit pend;

  task automatic model_reset();
    mx = HT - 1; my = VT - 1; p = 0; pend = 1'b0;
  endtask

  // One clock cycle: drive enable, enqueue the tick this cycle carries (if
  // any), then advance the divider model on enabled cycles.
  task automatic step(input bit en);
    exp_t e;
    enable = en;
    if (pend) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      e = model(mx, my);
      e.cyc = cyc;
      q.push_back(e);
    end
    if (en) begin
      p    = (p == DIV - 1) ? 0 : p + 1;
      pend = (p == DIV - 1);
    end else begin
      pend = 1'b0;
    end
    @(posedge clock_in); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic timeout(input string tag);
    n_tests++; n_fail++;
    $display("FAIL %s got timeout expected position reached", tag);
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (3) @(posedge clock_in);
    #1;
    reset = 1'b0;
    model_reset();

    // Two full frames' worth of frame_start plus line/sync statistics.
    run(2200);

    // Freeze mid-line with the divider mid-count.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (mx == 10 && p == 1 && !pend) found = 1'b1;
      else step(1'b1);
    end
    if (!found) timeout("wait_x10");
    repeat (37) step(1'b0);
    run(60);

    // Drop enable during a tick cycle: the tick stands, freeze follows.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend) found = 1'b1;
      else step(1'b1);
    end
    if (!found) timeout("wait_tick");
    repeat (5) step(1'b0);
    run(40);

    // Reset mid-frame.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (mx == 14 && my == 7 && p == 1) found = 1'b1;
      else step(1'b1);
    end
    if (!found) timeout("wait_x14_y7");
    reset = 1'b1;
    q.delete();
    model_reset();
    repeat (2) @(posedge clock_in);
    #1;
    reset = 1'b0;
    run(300);

    repeat (2) @(negedge clock_in);
    chk_int("queue_drained", q.size(), 0);
    for (int k = 0; k < 18; k++) chk_int("directed_visited", int'(dir_hit[k]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
